// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8N2 UART transmitter with start/busy handshake; even parity bit when UART_TX_PARITY_EN is defined
module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx_stream
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx: CLKS_PER_BIT must be >= 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] baud_cnt, baud_next;
    logic [2:0]    bit_idx, bit_next;
    logic          stop_cnt, stop_next;
    logic [7:0]    data_q;
    logic [7:0]    data_src;
    logic          load;
    logic          baud_last;
    logic          line_next;

    assign baud_last = (baud_cnt == BAUD_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            stop_cnt  <= 1'b0;
            data_q    <= '0;
            tx_stream <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= bit_next;
            stop_cnt  <= stop_next;
            tx_stream <= line_next;
            if (load) begin
                data_q <= tx_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        stop_next  = stop_cnt;
        load       = 1'b0;
        if (state != S_IDLE) begin
            baud_next = baud_last ? '0 : baud_cnt + 1'b1;
        end
        case (state)
            S_IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                stop_next = 1'b0;
                if (tx_start) begin
                    state_next = S_START;
                    load       = 1'b1;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    bit_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    if (stop_cnt == STOP_LAST) begin
                        state_next = S_IDLE;
                        stop_next  = 1'b0;
                    end else begin
                        stop_next = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The line register is loaded with the level of the state being entered,
    // so tx_stream always lines up with the registered state.
    always_comb begin
        data_src     = load ? tx_data : data_q;
        line_next    = 1'b1;
        tx_busy      = (state != S_IDLE);
        tx_done_tick = (state == S_STOP) && baud_last && (stop_cnt == STOP_LAST);
        case (state_next)
            S_IDLE:   line_next = 1'b1;
            S_START:  line_next = 1'b0;
            S_DATA:   line_next = data_src[bit_next];
`ifdef UART_TX_PARITY_EN
            S_PARITY: line_next = ^data_src;
`endif
            S_STOP:   line_next = 1'b1;
            default:  line_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx (16 clocks per bit)
module tb_uart_tx;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy, tx_done_tick, tx_stream;
    logic       tx_busy2, tx_done_tick2, tx_stream2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .STOP_BITS(1)) u_dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .tx_stream(tx_stream)
    );

    uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy2), .tx_done_tick(tx_done_tick2), .tx_stream(tx_stream2)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at the negedge before the accept edge with tx_start already high.
    task automatic run_frame(input string name, input logic [7:0] d, input logic [7:0] next_d,
                             input int sel, input int drop_at, input int poke_at);
        logic [11:0] bits;
        int nstop;
        int len;
        nstop = (sel != 0) ? 2 : 1;
        len = 9 + PAR_BITS + nstop;
        bits = 12'hFFF;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (PAR_BITS != 0) bits[9] = ^d;
        for (int c = 1; c <= len * CPB; c++) begin
            @(negedge clk);
            if (c == 1) tx_data = next_d;
            if (c == drop_at) tx_start = 1'b0;
            if (poke_at > 0 && c == poke_at) tx_start = 1'b1;
            if (poke_at > 0 && c == poke_at + 1) tx_start = 1'b0;
            chk($sformatf("%s line c%0d", name, c), (sel != 0) ? tx_stream2 : tx_stream, bits[(c-1)/CPB]);
            chk($sformatf("%s busy c%0d", name, c), (sel != 0) ? tx_busy2 : tx_busy, 1'b1);
            chk($sformatf("%s done c%0d", name, c), (sel != 0) ? tx_done_tick2 : tx_done_tick,
                (c == len * CPB) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_start = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset line", tx_stream, 1'b1);
        chk("reset busy", tx_busy, 1'b0);
        chk("reset done", tx_done_tick, 1'b0);
        rst = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk($sformatf("idle line c%0d", i), tx_stream, 1'b1);
            chk($sformatf("idle busy c%0d", i), tx_busy, 1'b0);
        end

        // 2: single 0x55 frame
        tx_start = 1'b1;
        tx_data = 8'h55;
        run_frame("f55", 8'h55, 8'h55, 0, 1, 0);
        @(negedge clk);
        chk("f55 after line", tx_stream, 1'b1);
        chk("f55 after busy", tx_busy, 1'b0);

        // 3: back-to-back with tx_start held high
        tx_start = 1'b1;
        tx_data = 8'hA3;
        run_frame("fA3", 8'hA3, 8'h0F, 0, 0, 0);
        @(negedge clk);
        chk("gap line", tx_stream, 1'b1);
        chk("gap busy", tx_busy, 1'b0);
        run_frame("f0F", 8'h0F, 8'h0F, 0, 1, 0);
        @(negedge clk);
        chk("f0F after busy", tx_busy, 1'b0);

        // 4: request mid-frame is dropped
        tx_start = 1'b1;
        tx_data = 8'hFF;
        run_frame("fFF", 8'hFF, 8'h3C, 0, 1, 40);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("nosecond line c%0d", i), tx_stream, 1'b1);
            chk($sformatf("nosecond busy c%0d", i), tx_busy, 1'b0);
        end

        // 5: reset at cycle 70 of a frame, line low at that moment
        tx_start = 1'b1;
        tx_data = 8'h00;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == 1) tx_start = 1'b0;
        end
        chk("prerst line", tx_stream, 1'b0);
        chk("prerst busy", tx_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst line", tx_stream, 1'b1);
        chk("midrst busy", tx_busy, 1'b0);
        chk("midrst done", tx_done_tick, 1'b0);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data = 8'h81;
        run_frame("f81", 8'h81, 8'h81, 0, 1, 0);
        @(negedge clk);
        chk("f81 after busy", tx_busy, 1'b0);

        // 6: two stop bits (plus parity when enabled) on the second instance
        repeat (40) @(negedge clk);
        chk("dut2 idle busy", tx_busy2, 1'b0);
        tx_start = 1'b1;
        tx_data = 8'h07;
        run_frame("f07s2", 8'h07, 8'h07, 1, 1, 0);
        @(negedge clk);
        chk("f07s2 after line", tx_stream2, 1'b1);
        chk("f07s2 after busy", tx_busy2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
